// File: rtl/matrix_ram_pipe_if.sv
// matrix_ram_pipe_if: bus bundle for matrix_ram_pipe.
//   clr/busy        : zero-fill request / sweep in progress
//   we/bea/dina/addra/wr_err : write port with byte enables and drop pulse
//   re/addrb/doutb/doutb_vld : read request and latency-tagged read stream
// master drives requests; slave is the RAM.
interface matrix_ram_pipe_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADNW       = 6
);
  logic                    clr;
  logic                    busy;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] bea;
  logic [DATA_WIDTH-1:0]   dina;
  logic [ADNW-1:0]         addra;
  logic                    wr_err;
  logic                    re;
  logic [ADNW-1:0]         addrb;
  logic [DATA_WIDTH-1:0]   doutb;
  logic                    doutb_vld;

  modport master (
    output clr, we, bea, dina, addra, re, addrb,
    input  busy, wr_err, doutb, doutb_vld
  );

  modport slave (
    input  clr, we, bea, dina, addra, re, addrb,
    output busy, wr_err, doutb, doutb_vld
  );
endinterface

// File: rtl/matrix_ram_pipe.sv
// matrix_ram_pipe: simple-dual-port distributed RAM with byte-enable writes,
// a RD_LATENCY-deep read pipeline with valid strobe, a zero-fill sweep after
// reset or on clr, defined read-during-write behaviour and range checking.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (starts a zero-fill sweep)
//   bus  : matrix_ram_pipe_if.slave (clr, busy, write port, read port)
module matrix_ram_pipe #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_NUM       = 32,
  parameter int ADNW           = 6,
  parameter int RD_LATENCY     = 2,
  parameter int COLLISION_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  matrix_ram_pipe_if.slave bus
);

  localparam int NBE = DATA_WIDTH / 8;
  localparam int AW  = (ADDR_NUM > 1) ? $clog2(ADDR_NUM) : 1;
  localparam logic [ADNW:0] ADDR_LIM  = (ADNW + 1)'(ADDR_NUM);
  localparam logic [AW-1:0] LAST_ADDR = AW'(ADDR_NUM - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   sweep_addr, sweep_addr_nxt;
  logic            busy;

  logic [DATA_WIDTH-1:0] mem [ADDR_NUM];

  logic                  wa_ok, ra_ok, wr_en, rd_en;
  logic [AW-1:0]         wa, ra;
  logic [DATA_WIDTH-1:0] wr_word, rd_word;

  logic [RD_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0] pdat [RD_LATENCY];
  logic                  wr_err;

  // ---------------- sweep FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      sweep_addr <= '0;
    end else begin
      state      <= state_nxt;
      sweep_addr <= sweep_addr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sweep_addr_nxt = sweep_addr;
    busy           = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (sweep_addr == LAST_ADDR) begin
          state_nxt      = IDLE;
          sweep_addr_nxt = '0;
        end else begin
          sweep_addr_nxt = sweep_addr + 1'b1;
        end
      end
      IDLE: begin
        if (bus.clr) begin
          state_nxt      = CLEAR;
          sweep_addr_nxt = '0;
        end
      end
    endcase
  end

  assign bus.busy = busy;

  // ---------------- address decode ----------------
  assign wa_ok = {1'b0, bus.addra} < ADDR_LIM;
  assign ra_ok = {1'b0, bus.addrb} < ADDR_LIM;
  assign wa    = bus.addra[AW-1:0];
  assign ra    = bus.addrb[AW-1:0];
  assign wr_en = bus.we && wa_ok && !busy;
  assign rd_en = bus.re && !busy;

  // Byte-merged post-write word; also the write-first collision result.
  always_comb begin
    wr_word = mem[wa];
    for (int unsigned i = 0; i < NBE; i++) begin
      if (bus.bea[i]) wr_word[8*i +: 8] = bus.dina[8*i +: 8];
    end
  end

  // ---------------- storage (no reset; defined by the sweep) ----------------
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[sweep_addr] <= '0;
    end else if (wr_en) begin
      mem[wa] <= wr_word;
    end
  end

  // Out-of-range reads yield zero; a same-address write either is ignored
  // (old data) or forwarded from the merge logic (new data).
  always_comb begin
    rd_word = '0;
    if (ra_ok) begin
      if (COLLISION_MODE == 1 && wr_en && bus.addra == bus.addrb) begin
        rd_word = wr_word;
      end else begin
        rd_word = mem[ra];
      end
    end
  end

  // ---------------- read pipeline ----------------
  // Data stages only load behind a valid, so doutb holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int unsigned k = 0; k < RD_LATENCY; k++) pdat[k] <= '0;
    end else begin
      vld[0] <= rd_en;
      if (rd_en) pdat[0] <= rd_word;
      for (int unsigned k = 1; k < RD_LATENCY; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) pdat[k] <= pdat[k-1];
      end
    end
  end

  assign bus.doutb     = pdat[RD_LATENCY-1];
  assign bus.doutb_vld = vld[RD_LATENCY-1];

  // ---------------- dropped-write pulse ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= bus.we && (!wa_ok || busy);
    end
  end

  assign bus.wr_err = wr_err;

endmodule

// File: tb/tb_matrix_ram_pipe.sv
// tb_matrix_ram_pipe: five matrix_ram_pipe instances share one directed
// stimulus stream: (latency 2, old-data), (latency 2, write-first),
// (latency 1), (latency 3), (latency 4). Reads push expected words into a
// scoreboard; one monitor checks every instance's read stream against it.
module tb_matrix_ram_pipe;
  localparam int DW = 64;
  localparam int NI = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        we  = 1'b0;
  logic        re  = 1'b0;
  logic [7:0]  bea = '0;
  logic [63:0] dina = '0;
  logic [5:0]  addra = '0;
  logic [5:0]  addrb = '0;

  logic        vld_a  [NI];
  logic [63:0] dout_a [NI];
  logic        busy_a [NI];
  logic        err_a  [NI];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      localparam int L = (g == 2) ? 1 : (g == 3) ? 3 : (g == 4) ? 4 : 2;
      localparam int M = (g == 1) ? 1 : 0;
      matrix_ram_pipe_if #(.DATA_WIDTH(DW), .ADNW(6)) bus ();
      assign bus.clr   = clr;
      assign bus.we    = we;
      assign bus.bea   = bea;
      assign bus.dina  = dina;
      assign bus.addra = addra;
      assign bus.re    = re;
      assign bus.addrb = addrb;
      assign vld_a[g]  = bus.doutb_vld;
      assign dout_a[g] = bus.doutb;
      assign busy_a[g] = bus.busy;
      assign err_a[g]  = bus.wr_err;
      matrix_ram_pipe #(
        .DATA_WIDTH(DW), .ADDR_NUM(32), .ADNW(6),
        .RD_LATENCY(L), .COLLISION_MODE(M)
      ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
      );
    end
  endgenerate

  typedef struct {
    int          cyc;
    logic [63:0] d0;
    logic [63:0] d1;
  } exp_t;

  exp_t exp_q[$];
  int   rd_idx [NI];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic int lat_of(input int k);
    case (k)
      2:       return 1;
      3:       return 3;
      4:       return 4;
      default: return 2;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: a request issued when cyc == c must appear once
  // cyc == c + latency, in issue order.
  always @(posedge clk) begin
    exp_t        e;
    logic [63:0] want;
    #1;
    for (int k = 0; k < NI; k++) begin
      if (vld_a[k]) begin
        checks++;
        if (rd_idx[k] >= exp_q.size()) begin
          errors++;
          $display("FAIL unexpected_valid inst %0d: doutb_vld=1 doutb=%h at cycle %0d, required no valid",
                   k, dout_a[k], cyc);
        end else begin
          e    = exp_q[rd_idx[k]];
          want = (k == 1) ? e.d1 : e.d0;
          rd_idx[k]++;
          if (dout_a[k] !== want || cyc != e.cyc + lat_of(k)) begin
            errors++;
            $display("FAIL read_data inst %0d: doutb=%h at cycle %0d, required %h at cycle %0d",
                     k, dout_a[k], cyc, want, e.cyc + lat_of(k));
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic op(input logic w, input logic [5:0] wa, input logic [7:0] be,
                    input logic [63:0] d, input logic err_exp,
                    input logic r, input logic [5:0] ra,
                    input logic [63:0] e0, input logic [63:0] e1, input logic push);
    we = w; addra = wa; bea = be; dina = d;
    re = r; addrb = ra;
    if (r && push) exp_q.push_back(exp_t'{cyc, e0, e1});
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
    if (w) chk("wr_err", {63'd0, err_a[0]}, {63'd0, err_exp});
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] be, input logic [63:0] d, input logic err);
    op(1'b1, a, be, d, err, 1'b0, 6'd0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic rd(input logic [5:0] a, input logic [63:0] e);
    op(1'b0, 6'd0, 8'd0, 64'd0, 1'b0, 1'b1, a, e, e, 1'b1);
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
    for (int k = 0; k < NI; k++) chk("all_reads_returned", 64'(rd_idx[k]), 64'(exp_q.size()));
  endtask

  // Counts negedges with busy high, starting at the current negedge;
  // optionally pulses clr at iteration clr_at.
  task automatic measure_busy(input int clr_at, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy_a[0]) break;
      n++;
      clr = (i == clr_at);
      @(negedge clk);
    end
    clr = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) rd_idx[k] = exp_q.size();
    repeat (2) @(negedge clk);
    chk("reset_busy",      {63'd0, busy_a[0]}, 64'd1);
    chk("reset_doutb",     dout_a[0], 64'd0);
    chk("reset_doutb_vld", {63'd0, vld_a[0]}, 64'd0);
    chk("reset_vld_lat4",  {63'd0, vld_a[4]}, 64'd0);
    chk("reset_wr_err",    {63'd0, err_a[0]}, 64'd0);
    rst = 1'b0;
    measure_busy(-1, n);
    chk("busy_cycles_after_reset", 64'(n), 64'd32);
  endtask

  function automatic logic [63:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {24'hC0FFEE, b, 24'h00BEEF, ~b};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < NI; k++) rd_idx[k] = 0;
    @(negedge clk);
    do_reset();

    // Post-reset contents are zero everywhere.
    for (int a = 0; a < 32; a++) rd(6'(a), 64'd0);
    drain();

    // Byte enables and bea = 0 no-op.
    wr(6'd5, 8'hFF, 64'h1122334455667788, 1'b0);
    wr(6'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0);
    rd(6'd5, 64'h11223344AAAAAAAA);
    wr(6'd5, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    rd(6'd5, 64'h11223344AAAAAAAA);

    // Collision: old data vs write-first, then the write is visible to both.
    wr(6'd3, 8'hFF, 64'h1, 1'b0);
    op(1'b1, 6'd3, 8'hFF, 64'h2, 1'b0, 1'b1, 6'd3, 64'h1, 64'h2, 1'b1);
    rd(6'd3, 64'h2);

    // Out-of-range writes (consecutive pulses) and out-of-range read.
    wr(6'd40, 8'hFF, 64'hDEAD, 1'b1);
    wr(6'd63, 8'hFF, 64'hBEEF, 1'b1);
    wr(6'd6,  8'hFF, 64'h66, 1'b0);
    rd(6'd40, 64'd0);
    rd(6'd6,  64'h66);
    drain();

    // Write and read during a sweep are dropped.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    op(1'b1, 6'd7, 8'hFF, 64'h77, 1'b1, 1'b1, 6'd5, 64'd0, 64'd0, 1'b0);
    measure_busy(-1, n);
    chk("busy_cycles_after_busy_write", 64'(n), 64'd31);
    rd(6'd7, 64'd0);
    rd(6'd5, 64'd0);
    rd(6'd6, 64'd0);
    drain();

    // Fill, read back, then clr with a second clr ignored mid-sweep.
    for (int a = 0; a < 32; a++) wr(6'(a), 8'hFF, pat(a), 1'b0);
    for (int a = 0; a < 32; a++) rd(6'(a), pat(a));
    drain();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    measure_busy(9, n);
    chk("busy_cycles_after_clr", 64'(n), 64'd32);
    repeat (3) @(negedge clk);
    chk("busy_low_after_sweep", {63'd0, busy_a[0]}, 64'd0);
    for (int a = 0; a < 32; a++) rd(6'(a), 64'd0);
    drain();

    // Streaming reads across all latencies, then reset mid-stream.
    for (int a = 0; a < 16; a++) wr(6'(a), 8'hFF, 64'hC0DE_0000_0000_0000 | 64'(a), 1'b0);
    for (int a = 0; a < 16; a++) rd(6'(a), 64'hC0DE_0000_0000_0000 | 64'(a));
    drain();
    for (int a = 0; a < 8; a++) rd(6'(a), 64'hC0DE_0000_0000_0000 | 64'(a));
    do_reset();
    drain();
    rd(6'd3, 64'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
